// File: rtl/data_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// data_transfer_sequencer
//
// Multi-cycle sequencer for the data-transfer instructions PUSH, PUSH_I,
// PUSH_T and POP. It takes a decoded opcode plus operand from the control
// unit and drives the RAM read/write strobes and the stack push/pop strobes
// in the right order. Completion or an error code goes back to the control
// unit through a start/busy/done handshake.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   start      : request, sampled only while busy is low
//   opcode     : 0=PUSH, 1=PUSH_I, 2=PUSH_T, 3=POP, anything else illegal
//   operand    : RAM address (PUSH/POP) or immediate value (PUSH_I)
//   temp1      : temp register value used by PUSH_T
//   busy       : high from the cycle after an accepted start through done
//   done       : one-cycle completion pulse
//   err        : 00 ok, 01 overflow, 10 underflow, 11 illegal opcode;
//                held until the next accepted start
//   ram_addr   : RAM address
//   ram_rd_en  : RAM read strobe (read data arrives one cycle later)
//   ram_q      : RAM read data
//   ram_wr_en  : RAM write strobe
//   ram_d      : RAM write data
//   stk_push   : stack push strobe
//   stk_pop    : stack pop strobe
//   stk_din    : stack push data
//   stk_tos    : current top of stack
//   stk_full   : stack full status
//   stk_empty  : stack empty status
// -----------------------------------------------------------------------------
module data_transfer_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] operand,
  input  logic [DATA_W-1:0] temp1,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_d,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_tos,
  input  logic              stk_full,
  input  logic              stk_empty
);

  localparam logic [OPC_W-1:0] OP_PUSH   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_PUSH_I = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_PUSH_T = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_POP    = OPC_W'(3);

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    RAM_RD,
    RAM_WAIT,
    STK_PUSH,
    STK_POP,
    RAM_WR,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t next_state;

  logic [OPC_W-1:0]  opc_q;
  logic [ADDR_W-1:0] operand_q;
  logic [DATA_W-1:0] temp_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;
  logic [1:0]        err_code;
  logic              accept;

  logic              busy_nxt;
  logic              done_nxt;
  logic              ram_rd_en_nxt;
  logic              ram_wr_en_nxt;
  logic              stk_push_nxt;
  logic              stk_pop_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [1:0]        err_nxt;

  // A request is only taken while the sequencer sits in IDLE (busy low).
  assign accept = (state == IDLE) && start;

  // Both data outputs come straight from the data register, so they only
  // move on the capture edges and stay put while their strobe is high.
  assign stk_din = data_q;
  assign ram_d   = data_q;

  // State register. Reset wins over everything, including a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Stack status is looked at only in DECODE, which is
  // also where the error code for a rejected request is chosen.
  always_comb begin
    next_state = state;
    err_code   = ERR_OK;
    unique case (state)
      IDLE: begin
        if (start) next_state = DECODE;
      end
      DECODE: begin
        if (opc_q == OP_PUSH || opc_q == OP_PUSH_I || opc_q == OP_PUSH_T) begin
          if (stk_full) begin
            next_state = ERR;
            err_code   = ERR_OVERFLOW;
          end else if (opc_q == OP_PUSH) begin
            next_state = RAM_RD;
          end else begin
            next_state = STK_PUSH;
          end
        end else if (opc_q == OP_POP) begin
          if (stk_empty) begin
            next_state = ERR;
            err_code   = ERR_UNDERFLOW;
          end else begin
            next_state = STK_POP;
          end
        end else begin
          next_state = ERR;
          err_code   = ERR_ILLEGAL;
        end
      end
      RAM_RD:   next_state = RAM_WAIT;
      RAM_WAIT: next_state = STK_PUSH;
      STK_PUSH: next_state = DONE;
      STK_POP:  next_state = RAM_WR;
      RAM_WR:   next_state = DONE;
      DONE:     next_state = IDLE;
      ERR:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic. Every strobe and status output is computed from the state
  // being entered and then registered, so each one comes out of a flop and
  // cannot glitch. Only one of the strobe states can be entered at a time,
  // which keeps the strobes mutually exclusive.
  always_comb begin
    busy_nxt      = (next_state != IDLE);
    done_nxt      = (next_state == DONE) || (next_state == ERR);
    ram_rd_en_nxt = (next_state == RAM_RD);
    ram_wr_en_nxt = (next_state == RAM_WR);
    stk_push_nxt  = (next_state == STK_PUSH);
    stk_pop_nxt   = (next_state == STK_POP);

    ram_addr_nxt = ram_addr;
    if (next_state == RAM_RD || next_state == RAM_WR) ram_addr_nxt = operand_q;

    err_nxt = err;
    if (accept)             err_nxt = ERR_OK;
    if (next_state == DONE) err_nxt = ERR_OK;
    if (next_state == ERR)  err_nxt = err_code;

    data_nxt = data_q;
    unique case (state)
      DECODE: begin
        if (opc_q == OP_PUSH_I)      data_nxt = DATA_W'(operand_q);
        else if (opc_q == OP_PUSH_T) data_nxt = temp_q;
      end
      RAM_WAIT: data_nxt = ram_q;
      STK_POP:  data_nxt = stk_tos;
      default:  data_nxt = data_q;
    endcase
  end

  // Registered handshake, strobe and address outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      ram_addr  <= '0;
      err       <= ERR_OK;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      ram_rd_en <= ram_rd_en_nxt;
      ram_wr_en <= ram_wr_en_nxt;
      stk_push  <= stk_push_nxt;
      stk_pop   <= stk_pop_nxt;
      ram_addr  <= ram_addr_nxt;
      err       <= err_nxt;
    end
  end

  // Request latches and the data register. The request fields are captured
  // once on accept so later changes on the inputs cannot disturb an
  // operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      opc_q     <= '0;
      operand_q <= '0;
      temp_q    <= '0;
      data_q    <= '0;
    end else begin
      if (accept) begin
        opc_q     <= opcode;
        operand_q <= operand;
        temp_q    <= temp1;
      end
      data_q <= data_nxt;
    end
  end

endmodule

// File: tb/tb_data_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_data_transfer_sequencer
//
// Directed bench for data_transfer_sequencer. Each request pushes the
// strobes and done pulse it should produce (kind, cycle, address/data/err)
// onto a scoreboard queue; a negedge monitor pops one entry every time the
// DUT raises a strobe or done and compares it. The stimulus task also checks
// busy cycle by cycle and the err hold/clear behaviour.
// -----------------------------------------------------------------------------
module tb_data_transfer_sequencer;

  localparam logic [4:0] EV_RD   = 5'b10000;
  localparam logic [4:0] EV_WR   = 5'b01000;
  localparam logic [4:0] EV_PUSH = 5'b00100;
  localparam logic [4:0] EV_POP  = 5'b00010;
  localparam logic [4:0] EV_DONE = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] vec;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] opcode;
  logic [7:0] operand;
  logic [7:0] temp1;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] ram_addr;
  logic       ram_rd_en;
  logic [7:0] ram_q;
  logic       ram_wr_en;
  logic [7:0] ram_d;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_tos;
  logic       stk_full;
  logic       stk_empty;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   mon_en     = 1'b0;
  exp_t sb[$];
  logic [7:0] mem [256];

  data_transfer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .operand   (operand),
    .temp1     (temp1),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_addr  (ram_addr),
    .ram_rd_en (ram_rd_en),
    .ram_q     (ram_q),
    .ram_wr_en (ram_wr_en),
    .ram_d     (ram_d),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_tos   (stk_tos),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  // Free-running clock and a cycle counter that the expectations refer to.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with one cycle of read latency.
  initial begin
    ram_q = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 3 + 1) ^ 8'h5A);
    mem[8'h10] = 8'h07;
  end

  always @(posedge clk) begin
    if (ram_rd_en) ram_q <= mem[ram_addr];
  end

  // Single comparison point: counts, asserts, and reports on a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expectEvent(input string tag, input logic [4:0] vec, input int c,
                                      input logic [7:0] addr, input logic [7:0] data,
                                      input logic [1:0] e);
    exp_t x;
    x.tag  = tag;
    x.vec  = vec;
    x.cyc  = c;
    x.addr = addr;
    x.data = data;
    x.err  = e;
    sb.push_back(x);
  endfunction

  // Scoreboard monitor: every strobe/done seen is matched against the next
  // expected entry, including the cycle it was supposed to appear in.
  always @(negedge clk) begin : monitor
    logic [4:0] vec;
    exp_t       e;
    if (mon_en) begin
      vec = {ram_rd_en, ram_wr_en, stk_push, stk_pop, done};
      if (vec !== 5'b00000) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", 32'(vec), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.tag, "_strobes"}, 32'(vec), 32'(e.vec));
          checkOutput({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
          case (e.vec)
            EV_RD:   checkOutput({e.tag, "_rd_addr"}, 32'(ram_addr), 32'(e.addr));
            EV_WR: begin
              checkOutput({e.tag, "_wr_addr"}, 32'(ram_addr), 32'(e.addr));
              checkOutput({e.tag, "_wr_data"}, 32'(ram_d), 32'(e.data));
            end
            EV_PUSH: checkOutput({e.tag, "_push_din"}, 32'(stk_din), 32'(e.data));
            EV_DONE: checkOutput({e.tag, "_err"}, 32'(err), 32'(e.err));
            default: ;
          endcase
        end
      end
    end
  end

  // Issues one request at a negedge, queues its expected events from the
  // bench's own model, then walks the cycles to the one after done checking
  // busy. With glitch set, start is held high with junk fields while busy.
  task automatic applyStimulus(input string tag, input logic [4:0] opc, input logic [7:0] opnd,
                               input logic [7:0] tmp, input bit glitch);
    int         c0;
    int         lat;
    logic [1:0] code;
    @(negedge clk);
    opcode  = opc;
    operand = opnd;
    temp1   = tmp;
    start   = 1'b1;
    c0      = cyc;
    code    = 2'b00;
    if (opc <= 5'd2 && stk_full)        code = 2'b01;
    else if (opc == 5'd3 && stk_empty)  code = 2'b10;
    else if (opc > 5'd3)                code = 2'b11;

    if (code != 2'b00) begin
      lat = 2;
    end else begin
      case (opc)
        5'd0: begin
          expectEvent(tag, EV_RD, c0 + 2, opnd, 8'h00, 2'b00);
          expectEvent(tag, EV_PUSH, c0 + 4, 8'h00, mem[opnd], 2'b00);
          lat = 5;
        end
        5'd1: begin
          expectEvent(tag, EV_PUSH, c0 + 2, 8'h00, opnd, 2'b00);
          lat = 3;
        end
        5'd2: begin
          expectEvent(tag, EV_PUSH, c0 + 2, 8'h00, tmp, 2'b00);
          lat = 3;
        end
        default: begin
          expectEvent(tag, EV_POP, c0 + 2, 8'h00, 8'h00, 2'b00);
          expectEvent(tag, EV_WR, c0 + 3, opnd, stk_tos, 2'b00);
          lat = 4;
        end
      endcase
    end
    expectEvent(tag, EV_DONE, c0 + lat, 8'h00, 8'h00, code);

    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_busy_c%0d", tag, k), 32'(busy), (k <= lat) ? 32'd1 : 32'd0);
      if (k == 1) checkOutput({tag, "_err_cleared"}, 32'(err), 32'd0);
      start = glitch && (k <= lat);
      if (glitch) begin
        opcode  = 5'd1;
        operand = 8'hEE;
        temp1   = 8'hDD;
      end
    end
    checkOutput({tag, "_err_held"}, 32'(err), 32'(code));
  endtask

  // All outputs at their reset values.
  task automatic checkZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_strobes"}, 32'({ram_rd_en, ram_wr_en, stk_push, stk_pop}), 32'd0);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_ram_d"}, 32'(ram_d), 32'd0);
    checkOutput({tag, "_stk_din"}, 32'(stk_din), 32'd0);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [4:0] ropc;
    int         c0;
    reset     = 1'b1;
    start     = 1'b0;
    opcode    = 5'd0;
    operand   = 8'h00;
    temp1     = 8'h00;
    stk_tos   = 8'h00;
    stk_full  = 1'b0;
    stk_empty = 1'b0;

    // Reset with start high: reset must win.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkZero("reset");
    start  = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    $display("[TB] basic pushes");
    applyStimulus("push_i_5", 5'd1, 8'h05, 8'h00, 1'b0);
    applyStimulus("push_10", 5'd0, 8'h10, 8'h00, 1'b0);
    applyStimulus("push_t_7", 5'd2, 8'hAB, 8'h07, 1'b0);

    $display("[TB] pop with start held during busy");
    stk_tos = 8'h0C;
    applyStimulus("pop_20", 5'd3, 8'h20, 8'h00, 1'b1);

    $display("[TB] error cases");
    stk_full = 1'b1;
    applyStimulus("ovf_push_i", 5'd1, 8'h09, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("ovf_err_idle_hold", 32'(err), 32'd1);
    applyStimulus("ovf_push_t", 5'd2, 8'h00, 8'h44, 1'b0);
    stk_tos = 8'h5A;
    applyStimulus("pop_when_full", 5'd3, 8'h21, 8'h00, 1'b0);
    stk_full  = 1'b0;
    stk_empty = 1'b1;
    applyStimulus("unf_pop", 5'd3, 8'h40, 8'h00, 1'b0);
    applyStimulus("push_when_empty", 5'd1, 8'h66, 8'h00, 1'b0);
    stk_empty = 1'b0;
    applyStimulus("illegal", 5'b10101, 8'h12, 8'h34, 1'b0);
    applyStimulus("push_i_clear", 5'd1, 8'h33, 8'h00, 1'b0);

    $display("[TB] reset in the middle of PUSH");
    @(negedge clk);
    opcode  = 5'd0;
    operand = 8'h30;
    start   = 1'b1;
    c0      = cyc;
    expectEvent("rst_push", EV_RD, c0 + 2, 8'h30, 8'h00, 2'b00);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkZero("mid_reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus("push_i_3", 5'd1, 8'h03, 8'h00, 1'b0);

    $display("[TB] a few random legal requests");
    for (int i = 0; i < 4; i++) begin
      ropc    = 5'($urandom_range(0, 3));
      stk_tos = 8'($urandom_range(0, 255));
      applyStimulus($sformatf("rand%0d", i), ropc, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
